// File: rtl/tm_lif_pkg.sv
// Shared constants and types for the time-multiplexed LIF neuron scheduler.
package tm_lif_pkg;

    localparam int NUM_NEURONS = 8;
    localparam int STATE_W     = 8;
    localparam int REFRAC_W    = 3;
    localparam int LEAK_SHIFT  = 1;
    localparam int IDX_W       = $clog2(NUM_NEURONS);

    localparam logic [STATE_W-1:0] THRESH_RST = STATE_W'(127);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } fsm_e;

    typedef struct packed {
        logic [STATE_W-1:0]  thresh;
        logic [REFRAC_W-1:0] refrac;
    } neuron_cfg_t;

endpackage

// File: rtl/tm_lif_update.sv
// Combinational leak / saturating integrate / threshold / refractory step for one neuron.
module tm_lif_update
    import tm_lif_pkg::*;
(
    input  logic [STATE_W-1:0]  state_i,
    input  logic [REFRAC_W-1:0] refrac_cnt_i,
    input  neuron_cfg_t         cfg_i,
    input  logic [STATE_W-1:0]  current_i,
    output logic [STATE_W-1:0]  next_state_o,
    output logic [REFRAC_W-1:0] next_refrac_o,
    output logic                fire_o
);

    logic [STATE_W:0]   sum_wide;
    logic [STATE_W-1:0] sum_sat;

    // One extra bit catches the carry so the sum clamps at all-ones instead of wrapping.
    assign sum_wide = {1'b0, current_i} + {1'b0, (state_i >> LEAK_SHIFT)};
    assign sum_sat  = sum_wide[STATE_W] ? {STATE_W{1'b1}} : sum_wide[STATE_W-1:0];

    always_comb begin
        next_state_o  = state_i;
        next_refrac_o = refrac_cnt_i;
        fire_o        = 1'b0;
        if (refrac_cnt_i != '0) begin
            next_refrac_o = refrac_cnt_i - 1'b1;
            next_state_o  = '0;
        end else if (sum_sat >= cfg_i.thresh) begin
            fire_o        = 1'b1;
            next_state_o  = '0;
            next_refrac_o = cfg_i.refrac;
        end else begin
            next_state_o  = sum_sat;
        end
    end

endmodule

// File: rtl/tm_lif_scheduler.sv
// Sweeps all neurons through one shared LIF datapath per tick and emits spikes
// as a valid/ready address-event stream.
module tm_lif_scheduler
    import tm_lif_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick_valid,
    output logic                   tick_ready,
    output logic [IDX_W-1:0]       cur_idx,
    input  logic [STATE_W-1:0]     cur_data,
    input  logic                   cfg_we,
    input  logic [IDX_W-1:0]       cfg_addr,
    input  logic [STATE_W-1:0]     cfg_thresh,
    input  logic [REFRAC_W-1:0]    cfg_refrac,
    output logic                   spike_valid,
    input  logic                   spike_ready,
    output logic [IDX_W-1:0]       spike_idx,
    output logic [NUM_NEURONS-1:0] spike_vec,
    output logic                   busy,
    output logic                   sweep_done
);

    fsm_e                                      fsm_q, fsm_d;
    logic [IDX_W-1:0]                          idx_q, idx_d;
    logic [NUM_NEURONS-1:0][STATE_W-1:0]       state_q;
    logic [NUM_NEURONS-1:0][REFRAC_W-1:0]      refrac_q;
    neuron_cfg_t [NUM_NEURONS-1:0]             cfg_q;
    logic                                      spk_valid_q, spk_valid_d;
    logic [IDX_W-1:0]                          spk_idx_q, spk_idx_d;
    logic [NUM_NEURONS-1:0]                    spk_vec_q, spk_vec_d;
    logic [NUM_NEURONS-1:0]                    sweep_spk_q, sweep_spk_d;

    logic                slot_free, do_proc, last_idx;
    logic [STATE_W-1:0]  upd_state;
    logic [REFRAC_W-1:0] upd_refrac;
    logic                upd_fire;

    // A neuron is only evaluated when its possible event has somewhere to go.
    assign slot_free = !spk_valid_q || spike_ready;
    assign do_proc   = (fsm_q == ST_UPDATE) && slot_free;
    assign last_idx  = (idx_q == IDX_W'(NUM_NEURONS - 1));

    tm_lif_update u_update (
        .state_i      (state_q[idx_q]),
        .refrac_cnt_i (refrac_q[idx_q]),
        .cfg_i        (cfg_q[idx_q]),
        .current_i    (cur_data),
        .next_state_o (upd_state),
        .next_refrac_o(upd_refrac),
        .fire_o       (upd_fire)
    );

    always_comb begin
        fsm_d = fsm_q;
        idx_d = idx_q;
        case (fsm_q)
            ST_IDLE: begin
                if (tick_valid) begin
                    fsm_d = ST_UPDATE;
                    idx_d = '0;
                end
            end
            ST_UPDATE: begin
                if (do_proc) begin
                    if (last_idx) fsm_d = ST_DRAIN;
                    else          idx_d = idx_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!spk_valid_q || spike_ready) fsm_d = ST_DONE;
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_comb begin
        spk_valid_d = spk_valid_q && !spike_ready;
        spk_idx_d   = spk_idx_q;
        sweep_spk_d = sweep_spk_q;
        spk_vec_d   = spk_vec_q;
        if (fsm_q == ST_IDLE && tick_valid) sweep_spk_d = '0;
        if (do_proc && upd_fire) begin
            spk_valid_d        = 1'b1;
            spk_idx_d          = idx_q;
            sweep_spk_d[idx_q] = 1'b1;
        end
        if (fsm_q == ST_DRAIN && fsm_d == ST_DONE) spk_vec_d = sweep_spk_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= ST_IDLE;
            idx_q       <= '0;
            spk_valid_q <= 1'b0;
            spk_idx_q   <= '0;
            spk_vec_q   <= '0;
            sweep_spk_q <= '0;
        end else begin
            fsm_q       <= fsm_d;
            idx_q       <= idx_d;
            spk_valid_q <= spk_valid_d;
            spk_idx_q   <= spk_idx_d;
            spk_vec_q   <= spk_vec_d;
            sweep_spk_q <= sweep_spk_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= '0;
            refrac_q <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                cfg_q[i].thresh <= THRESH_RST;
                cfg_q[i].refrac <= '0;
            end
        end else begin
            if (do_proc) begin
                state_q[idx_q]  <= upd_state;
                refrac_q[idx_q] <= upd_refrac;
            end
            // Configuration only lands between sweeps; running counters are untouched.
            if (fsm_q == ST_IDLE && cfg_we) begin
                cfg_q[cfg_addr].thresh <= cfg_thresh;
                cfg_q[cfg_addr].refrac <= cfg_refrac;
            end
        end
    end

    assign tick_ready  = (fsm_q == ST_IDLE);
    assign busy        = (fsm_q != ST_IDLE);
    assign sweep_done  = (fsm_q == ST_DONE);
    assign cur_idx     = idx_q;
    assign spike_valid = spk_valid_q;
    assign spike_idx   = spk_idx_q;
    assign spike_vec   = spk_vec_q;

endmodule

// File: tb/tb_tm_lif_scheduler.sv
// Directed and randomized checks of tm_lif_scheduler against an arithmetic neuron model.
module tb_tm_lif_scheduler;
    import tm_lif_pkg::*;

    logic                   clk, rst, tick_valid, tick_ready;
    logic [IDX_W-1:0]       cur_idx, cfg_addr, spike_idx;
    logic [STATE_W-1:0]     cur_data, cfg_thresh;
    logic                   cfg_we, spike_valid, spike_ready, busy, sweep_done;
    logic [REFRAC_W-1:0]    cfg_refrac;
    logic [NUM_NEURONS-1:0] spike_vec;

    logic [STATE_W-1:0] cur_tbl [NUM_NEURONS];
    assign cur_data = cur_tbl[cur_idx];

    tm_lif_scheduler dut (
        .clk(clk), .rst(rst), .tick_valid(tick_valid), .tick_ready(tick_ready),
        .cur_idx(cur_idx), .cur_data(cur_data), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_thresh(cfg_thresh), .cfg_refrac(cfg_refrac), .spike_valid(spike_valid),
        .spike_ready(spike_ready), .spike_idx(spike_idx), .spike_vec(spike_vec),
        .busy(busy), .sweep_done(sweep_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference: membrane, threshold, refractory length and live refractory count per neuron.
    int m_state [NUM_NEURONS];
    int m_th    [NUM_NEURONS];
    int m_rf    [NUM_NEURONS];
    int m_cnt   [NUM_NEURONS];
    int m_exp_q [$];
    logic [NUM_NEURONS-1:0] m_exp_vec;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NUM_NEURONS; i++) begin
            m_state[i] = 0; m_th[i] = 127; m_rf[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic m_tick();
        int sum;
        m_exp_q.delete();
        m_exp_vec = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (m_cnt[i] > 0) begin
                m_cnt[i]--; m_state[i] = 0;
            end else begin
                sum = int'(cur_tbl[i]) + m_state[i] / (2 ** LEAK_SHIFT);
                if (sum > 2 ** STATE_W - 1) sum = 2 ** STATE_W - 1;
                if (sum >= m_th[i]) begin
                    m_state[i] = 0; m_cnt[i] = m_rf[i];
                    m_exp_q.push_back(i); m_exp_vec[i] = 1'b1;
                end else begin
                    m_state[i] = sum;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    task automatic cfg_write(input int a, input int th, input int rf);
        cfg_we = 1'b1; cfg_addr = IDX_W'(a); cfg_thresh = STATE_W'(th); cfg_refrac = REFRAC_W'(rf);
        @(negedge clk);
        cfg_we = 1'b0;
        m_th[a] = th; m_rf[a] = rf;
    endtask

    task automatic set_cur(input int v);
        for (int i = 0; i < NUM_NEURONS; i++) cur_tbl[i] = STATE_W'(v);
    endtask

    // Runs one sweep from an IDLE negedge; returns at an IDLE negedge.
    task automatic sweep(input int ready_pct, input int stall, input bit poke, input bit chk_lat);
        int got_q [$];
        int cyc, stall_left;
        bit done, first_seen;
        logic [IDX_W-1:0] hold_idx;
        got_q.delete();
        m_tick();
        check("tick_ready_idle", 32'(tick_ready), 32'd1);
        tick_valid = 1'b1;
        @(negedge clk);
        tick_valid = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        cyc = 1; done = 0; first_seen = 0; stall_left = stall; hold_idx = '0;
        while (!done && cyc < 2000) begin
            if (stall > 0 && spike_valid && !first_seen) begin
                first_seen = 1; hold_idx = cur_idx;
            end
            if (first_seen && stall_left > 0) begin
                spike_ready = 1'b0;
                stall_left--;
                if (stall_left == 0) check("idx_held_stall", 32'(cur_idx), 32'(hold_idx));
            end else begin
                spike_ready = ($urandom_range(99) < ready_pct);
            end
            if (poke && cyc == 3) begin
                tick_valid = 1'b1; cfg_we = 1'b1; cfg_addr = 2; cfg_thresh = 5; cfg_refrac = 0;
            end else begin
                tick_valid = 1'b0; cfg_we = 1'b0;
            end
            if (spike_valid && spike_ready) got_q.push_back(int'(spike_idx));
            if (sweep_done) done = 1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        tick_valid = 1'b0; cfg_we = 1'b0;
        check("sweep_finished", 32'(done), 32'd1);
        if (chk_lat) check("latency", 32'(cyc), 32'(NUM_NEURONS + 2));
        check("valid_clear_at_done", 32'(spike_valid), 32'd0);
        check("event_count", 32'(got_q.size()), 32'(m_exp_q.size()));
        for (int k = 0; k < m_exp_q.size() && k < got_q.size(); k++)
            check("event_idx", 32'(got_q[k]), 32'(m_exp_q[k]));
        check("spike_vec", 32'(spike_vec), 32'(m_exp_vec));
        @(negedge clk);
        check("done_one_cycle", 32'(sweep_done), 32'd0);
        check("idle_after_done", 32'(tick_ready), 32'd1);
        spike_ready = 1'b1;
    endtask

    initial begin
        int waitc;
        rst = 1'b1; tick_valid = 1'b0; cfg_we = 1'b0; cfg_addr = '0;
        cfg_thresh = '0; cfg_refrac = '0; spike_ready = 1'b1;
        set_cur(0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        m_reset();

        check("rst_tick_ready", 32'(tick_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_spike_valid", 32'(spike_valid), 32'd0);
        check("rst_spike_idx", 32'(spike_idx), 32'd0);
        check("rst_spike_vec", 32'(spike_vec), 32'd0);
        check("rst_sweep_done", 32'(sweep_done), 32'd0);
        check("rst_cur_idx", 32'(cur_idx), 32'd0);

        // Integrate/leak: 64,96,...,127 fires on the seventh tick.
        set_cur(64);
        for (int t = 1; t <= 7; t++) begin
            sweep(100, 0, 0, t == 1);
            check("t1_n0_spike", 32'(spike_vec[0]), 32'(t == 7));
        end

        // Saturation: 200 then min(300,255) crosses threshold 255.
        do_reset();
        cfg_write(0, 255, 0);
        set_cur(200);
        for (int t = 1; t <= 2; t++) begin
            sweep(100, 0, 0, 0);
            check("t2_sat_spike", 32'(spike_vec[0]), 32'(t == 2));
        end

        // Refractory length 2: fires on ticks 1,4,7.
        do_reset();
        cfg_write(0, 127, 2);
        for (int t = 1; t <= 7; t++) begin
            sweep(100, 0, 0, 0);
            check("t3_refrac_spike", 32'(spike_vec[0]), 32'(t % 3 == 1));
        end

        // Backpressure: every neuron fires, downstream stalls five cycles.
        do_reset();
        for (int i = 0; i < NUM_NEURONS; i++) cfg_write(i, 0, 0);
        set_cur(1);
        sweep(100, 5, 0, 0);
        check("t4_all_fire", 32'(spike_vec), 32'hFF);

        // Reset mid-sweep with an event pending.
        do_reset();
        for (int i = 0; i < NUM_NEURONS; i++) cfg_write(i, 0, 0);
        tick_valid = 1'b1;
        @(negedge clk);
        tick_valid = 1'b0;
        waitc = 0;
        while (!(busy && cur_idx == 3) && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        check("t5_reached_idx3", 32'(waitc < 50), 32'd1);
        check("t5_valid_before_rst", 32'(spike_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_valid_after_rst", 32'(spike_valid), 32'd0);
        check("t5_ready_after_rst", 32'(tick_ready), 32'd1);
        check("t5_vec_after_rst", 32'(spike_vec), 32'd0);
        check("t5_idx_after_rst", 32'(cur_idx), 32'd0);
        rst = 1'b0;
        m_reset();
        set_cur(64);
        sweep(100, 0, 0, 1);
        set_cur(100);
        sweep(100, 0, 0, 0);
        check("t5_thresh_127", 32'(spike_vec), 32'hFF);

        // Writes and ticks while busy are dropped; the same write in IDLE applies.
        set_cur(5);
        sweep(100, 0, 1, 0);
        check("t6_busy_cfg_ignored", 32'(spike_vec[2]), 32'd0);
        check("t6_no_queued_tick", 32'(busy), 32'd0);
        cfg_write(2, 5, 0);
        sweep(100, 0, 0, 0);
        check("t6_idle_cfg_applied", 32'(spike_vec[2]), 32'd1);

        // Random configuration, currents and downstream readiness.
        for (int r = 0; r < 20; r++) begin
            for (int w = 0; w < 3; w++)
                cfg_write($urandom_range(NUM_NEURONS - 1),
                          ($urandom_range(3) == 0) ? 0 : $urandom_range(255),
                          $urandom_range(7));
            for (int i = 0; i < NUM_NEURONS; i++) cur_tbl[i] = STATE_W'($urandom_range(255));
            sweep(60, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
